// File: rtl/jtag_tap_if.sv
// Pin-side and boundary-scan-chain-side signals of the TAP controller.
// The slave modport is the TAP itself; master is the pin/chain environment.
interface jtag_tap_if;
  logic       tms_i;
  logic       tdi_i;
  logic       tdo_o;
  logic       tdo_en_o;
  logic       bsr_scan_o;
  logic       bsr_scan_i;
  logic       bsr_shift_o;
  logic       bsr_capture_o;
  logic       bsr_update_o;
  logic       bsr_mode_o;
  logic [3:0] state_o;

  modport slave (
    input  tms_i, tdi_i, bsr_scan_i,
    output tdo_o, tdo_en_o, bsr_scan_o, bsr_shift_o, bsr_capture_o,
           bsr_update_o, bsr_mode_o, state_o
  );

  modport master (
    output tms_i, tdi_i, bsr_scan_i,
    input  tdo_o, tdo_en_o, bsr_scan_o, bsr_shift_o, bsr_capture_o,
           bsr_update_o, bsr_mode_o, state_o
  );
endinterface

// File: rtl/jtag_tap.sv
// IEEE 1149.1-style TAP controller driving the BSC boundary-scan chain.
// Define JTAG_TAP_IDCODE_EN to include the IDCODE register and make IDCODE the reset instruction.
//
// state  | meaning
// TLR    | test-logic-reset, active IR forced to reset opcode
// RTI    | run-test/idle
// SEL_DR | select DR scan
// CAP_DR | capture into selected DR
// SH_DR  | shift selected DR
// EX1_DR | exit1 DR
// PAU_DR | pause DR, shift registers frozen
// EX2_DR | exit2 DR
// UPD_DR | update DR
// SEL_IR | select IR scan
// CAP_IR | capture 0..01 into IR shift register
// SH_IR  | shift IR
// EX1_IR | exit1 IR
// PAU_IR | pause IR
// EX2_IR | exit2 IR
// UPD_IR | update active IR
module jtag_tap #(
  parameter int          IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input logic        tck,
  input logic        rst,
  jtag_tap_if.slave  bus
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
    SH_DR  = 4'h2, EX1_DR = 4'h1, PAU_DR = 4'h3, EX2_DR = 4'h0,
    UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
    EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_t;

  localparam logic [IR_W-1:0] OP_EXTEST = '0;
  localparam logic [IR_W-1:0] OP_SAMPLE = {{(IR_W-1){1'b0}}, 1'b1};
  localparam logic [IR_W-1:0] OP_IDCODE = {{(IR_W-2){1'b0}}, 2'b10};
  localparam logic [IR_W-1:0] OP_BYPASS = '1;
  localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-1){1'b0}}, 1'b1};
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] OP_RESET = OP_IDCODE;
`else
  localparam logic [IR_W-1:0] OP_RESET = OP_BYPASS;
`endif

  tap_state_t      state_q, state_d;
  logic [IR_W-1:0] ir_shift_q, ir_q;
  logic            bypass_q;
  logic            bsr_sel, idcode_sel;
`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0]     idcode_q;
`endif

  assign bsr_sel = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);
`ifdef JTAG_TAP_IDCODE_EN
  assign idcode_sel = (ir_q == OP_IDCODE);
`else
  assign idcode_sel = 1'b0;
`endif

  always_ff @(posedge tck) begin
    if (rst) begin
      state_q    <= TLR;
      ir_q       <= OP_RESET;
      ir_shift_q <= IR_CAPTURE;
      bypass_q   <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
      idcode_q   <= IDCODE_VAL;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        TLR:    ir_q       <= OP_RESET;
        CAP_IR: ir_shift_q <= IR_CAPTURE;
        SH_IR:  ir_shift_q <= {bus.tdi_i, ir_shift_q[IR_W-1:1]};
        UPD_IR: ir_q       <= ir_shift_q;
        CAP_DR: begin
          bypass_q <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
          idcode_q <= IDCODE_VAL;
`endif
        end
        SH_DR: begin
          bypass_q <= bus.tdi_i;
`ifdef JTAG_TAP_IDCODE_EN
          idcode_q <= {bus.tdi_i, idcode_q[31:1]};
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:                 state_d = bus.tms_i ? TLR    : RTI;
      RTI, UPD_DR, UPD_IR: state_d = bus.tms_i ? SEL_DR : RTI;
      SEL_DR:              state_d = bus.tms_i ? SEL_IR : CAP_DR;
      SEL_IR:              state_d = bus.tms_i ? TLR    : CAP_IR;
      CAP_DR, SH_DR:       state_d = bus.tms_i ? EX1_DR : SH_DR;
      EX1_DR:              state_d = bus.tms_i ? UPD_DR : PAU_DR;
      PAU_DR:              state_d = bus.tms_i ? EX2_DR : PAU_DR;
      EX2_DR:              state_d = bus.tms_i ? UPD_DR : SH_DR;
      CAP_IR, SH_IR:       state_d = bus.tms_i ? EX1_IR : SH_IR;
      EX1_IR:              state_d = bus.tms_i ? UPD_IR : PAU_IR;
      PAU_IR:              state_d = bus.tms_i ? EX2_IR : PAU_IR;
      EX2_IR:              state_d = bus.tms_i ? UPD_IR : SH_IR;
      default:             state_d = TLR;
    endcase
  end

  // Moore outputs: the chain acts on the edge that leaves the current state.
  always_comb begin
    bus.tdo_o         = 1'b0;
    bus.tdo_en_o      = (state_q == SH_IR) || (state_q == SH_DR);
    bus.bsr_scan_o    = bus.tdi_i;
    bus.bsr_capture_o = bsr_sel && ((state_q == CAP_DR) || (state_q == SH_DR));
    bus.bsr_shift_o   = bsr_sel && (state_q == SH_DR);
    bus.bsr_update_o  = bsr_sel && (state_q == UPD_DR);
    bus.bsr_mode_o    = (ir_q == OP_EXTEST) && (state_q != TLR);
    bus.state_o       = state_q;
    if (state_q == SH_IR) begin
      bus.tdo_o = ir_shift_q[0];
    end else if (state_q == SH_DR) begin
      if (bsr_sel)
        bus.tdo_o = bus.bsr_scan_i;
`ifdef JTAG_TAP_IDCODE_EN
      else if (idcode_sel)
        bus.tdo_o = idcode_q[0];
`endif
      else
        bus.tdo_o = bypass_q;
    end
  end

endmodule

// File: tb/tb_jtag_tap.sv
// Directed bench for jtag_tap with a small 8-cell behavioural BSC chain on the scan port.
// Expected values adapt to whether JTAG_TAP_IDCODE_EN is defined.
module tb_jtag_tap;
  localparam logic [31:0] IDV = 32'h1000_0001;

  logic tck = 1'b0;
  logic rst = 1'b1;
  always #5 tck = ~tck;

  jtag_tap_if bus();

  jtag_tap #(.IR_W(4), .IDCODE_VAL(IDV)) dut (
    .tck (tck),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural chain: shift right toward scan_o, capture data_in, update latch.
  logic [7:0] ch_sr   = 8'h00;
  logic [7:0] ch_upd  = 8'h00;
  logic [7:0] ch_din  = 8'h3C;
  logic [7:0] ch_dout;

  always @(posedge tck) begin
    if (bus.bsr_shift_o)        ch_sr <= {bus.bsr_scan_o, ch_sr[7:1]};
    else if (bus.bsr_capture_o) ch_sr <= ch_din;
    if (bus.bsr_update_o)       ch_upd <= ch_sr;
  end
  assign bus.bsr_scan_i = ch_sr[0];
  assign ch_dout = bus.bsr_mode_o ? ch_upd : ch_din;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic tms, input logic tdi);
    bus.tms_i = tms;
    bus.tdi_i = tdi;
    @(posedge tck);
    @(negedge tck);
  endtask

  // From RTI, scan val into the IR; ends in UPD_IR.
  task automatic ir_scan(input logic [3:0] val);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("ir_cap_tdo", bus.tdo_o, (i == 0) ? 32'd1 : 32'd0);
      check("ir_tdo_en", bus.tdo_en_o, 32'd1);
      step(i == 3, val[i]);
    end
    step(1'b1, 1'b0);
    check("upd_ir_state", bus.state_o, 32'hD);
  endtask

  logic [3:0]  walk [5] = '{4'h7, 4'h4, 4'hF, 4'hF, 4'hF};
  logic [31:0] dr_exp;
  int          dr_n;
  logic [7:0]  pat_a5 = 8'hA5;
  logic [3:0]  byp_in = 4'b1101;
  logic [3:0]  byp_out = 4'b1010;
  logic [7:0]  cap_val = 8'h3C;
  logic        first_bit;

  initial begin
    bus.tms_i = 1'b1;
    bus.tdi_i = 1'b0;
    rst = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("rst_state", bus.state_o, 32'hF);
    check("rst_mode", bus.bsr_mode_o, 32'd0);
    check("rst_ctrl", {bus.bsr_capture_o, bus.bsr_shift_o, bus.bsr_update_o}, 32'd0);
    check("rst_tdo", {bus.tdo_o, bus.tdo_en_o}, 32'd0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    check("rti_state", bus.state_o, 32'hC);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      check("walk_state", bus.state_o, walk[i]);
      check("walk_mode", bus.bsr_mode_o, 32'd0);
      check("walk_ctrl", {bus.bsr_capture_o, bus.bsr_shift_o, bus.bsr_update_o}, 32'd0);
    end

    // DR scan straight after reset: IDCODE or bypass bit
`ifdef JTAG_TAP_IDCODE_EN
    dr_n = 32; dr_exp = IDV;
`else
    dr_n = 8;  dr_exp = 32'd0;
`endif
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("capdr_tdo_en", bus.tdo_en_o, 32'd0);
    step(1'b0, 1'b0);
    for (int i = 0; i < dr_n; i++) begin
      check("id_tdo", bus.tdo_o, dr_exp[i]);
      check("id_tdo_en", bus.tdo_en_o, 32'd1);
      check("id_bsr_shift", bus.bsr_shift_o, 32'd0);
      step(i == dr_n - 1, 1'b0);
    end
    check("ex1dr_tdo_en", bus.tdo_en_o, 32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // EXTEST load; mode rises in the cycle after UPD_IR
    ir_scan(4'h0);
    check("mode_in_updir", bus.bsr_mode_o, 32'd0);
    step(1'b0, 1'b0);
    check("mode_after_updir", bus.bsr_mode_o, 32'd1);

    // 8-bit EXTEST DR scan of A5
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("capdr_capture", bus.bsr_capture_o, 32'd1);
    check("capdr_shift", bus.bsr_shift_o, 32'd0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("ext_shift", bus.bsr_shift_o, 32'd1);
      check("ext_tdo", bus.tdo_o, cap_val[i]);
      step(i == 7, pat_a5[i]);
    end
    check("ex1dr_shift", bus.bsr_shift_o, 32'd0);
    check("ex1dr_update", bus.bsr_update_o, 32'd0);
    step(1'b1, 1'b0);
    check("upddr_update", bus.bsr_update_o, 32'd1);
    step(1'b0, 1'b0);
    check("rti_update", bus.bsr_update_o, 32'd0);
    check("chain_data_a5", ch_dout, 32'hA5);
    check("ext_mode_held", bus.bsr_mode_o, 32'd1);

    // BYPASS: one-bit delay, BSR controls idle
    ir_scan(4'hF);
    step(1'b0, 1'b0);
    check("byp_mode", bus.bsr_mode_o, 32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("byp_capture", bus.bsr_capture_o, 32'd0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("byp_tdo", bus.tdo_o, byp_out[i]);
      check("byp_ctrl", {bus.bsr_capture_o, bus.bsr_shift_o}, 32'd0);
      step(i == 3, byp_in[i]);
    end
    step(1'b1, 1'b0);
    check("byp_update", bus.bsr_update_o, 32'd0);
    step(1'b0, 1'b0);

    // Reset in the middle of an EXTEST shift
    ir_scan(4'h0);
    step(1'b0, 1'b0);
    check("pre_rst_data", ch_dout, 32'hA5);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check("mid_scan_state", bus.state_o, 32'h2);
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    check("abort_state", bus.state_o, 32'hF);
    check("abort_mode", bus.bsr_mode_o, 32'd0);
    check("abort_shift", bus.bsr_shift_o, 32'd0);
    check("abort_data", ch_dout, 32'h3C);
`ifdef JTAG_TAP_IDCODE_EN
    first_bit = IDV[0];
`else
    first_bit = 1'b0;
`endif
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("abort_ir_tdo", bus.tdo_o, first_bit);
    check("abort_ir_shift", bus.bsr_shift_o, 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("final_state", bus.state_o, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
